// File: rtl/seg_pkg.sv
// seg_pkg: shared segment codes and scan-state encoding for the display scanner
package seg_pkg;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_ZERO  = 8'b00000010;
    localparam logic [7:0] SEG_ONE   = 8'b10011110;
    typedef enum logic [1:0] {IDLE, GUARD, DRIVE} scan_state_e;
endpackage

// File: rtl/refresh_tick_gen.sv
// refresh_tick_gen: free-running slot prescaler with clear, tick at terminal count
module refresh_tick_gen #(
    parameter int DIV = 100000,
    localparam int W = $clog2(DIV)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         run,
    output logic         tick,
    output logic [W-1:0] cnt
);
    assign tick = run && cnt == W'(DIV - 1);
    // count 0..DIV-1 while running; clear has priority so every slot starts at 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (run) cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/seg_display_scanner.sv
// seg_display_scanner: multiplexes stored segment codes onto a shared 7-segment bus with blanking guard
module seg_display_scanner
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYC    = 4,
    parameter bit AN_ACTIVE_LO = 1'b1,
    localparam int IW = $clog2(NUM_DIGITS),
    localparam int CW = $clog2(REFRESH_DIV)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  wr_en,
    input  logic [IW-1:0]         wr_idx,
    input  logic [7:0]            wr_seg,
    input  logic [NUM_DIGITS-1:0] blank_mask,
    output logic [NUM_DIGITS-1:0] an,
    output logic [7:0]            seg_out,
    output logic                  frame_done
);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_ACTIVE_LO}};
    scan_state_e           state, state_d;
    logic [IW-1:0]         ptr, ptr_d;
    logic [7:0]            regs [NUM_DIGITS];
    logic                  tick, clr, drive, last, fd_d;
    logic [CW-1:0]         cnt;
    logic [NUM_DIGITS-1:0] an_act, an_d;
    logic [7:0]            seg_d;

    assign clr  = !enable || state == IDLE;
    assign last = ptr == IW'(NUM_DIGITS - 1);

    refresh_tick_gen #(.DIV(REFRESH_DIV)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .run  (enable),
        .tick (tick),
        .cnt  (cnt)
    );

    // digit register file; writes accepted in any state, out-of-range indices dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) for (int i = 0; i < NUM_DIGITS; i++) regs[i] <= SEG_BLANK;
        else if (wr_en && int'(wr_idx) < NUM_DIGITS) regs[wr_idx] <= wr_seg;
    end

    // scan sequencing: guard slice at each slot start, then drive until the prescaler tick
    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        if (!enable) begin
            state_d = IDLE;
            ptr_d   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_d = GUARD;
                    ptr_d   = '0;
                end
                GUARD: state_d = cnt == CW'(BLANK_CYC - 1) ? DRIVE : GUARD;
                DRIVE: if (tick) begin
                    state_d = GUARD;
                    ptr_d   = last ? '0 : ptr + 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // next output values; gating with enable turns the bank off on the same edge as IDLE entry
    always_comb begin
        drive  = enable && state == DRIVE;
        an_act = drive ? NUM_DIGITS'(1) << ptr : '0;
        an_d   = AN_ACTIVE_LO ? ~an_act : an_act;
        seg_d  = drive && !blank_mask[ptr] ? regs[ptr] : SEG_BLANK;
        fd_d   = drive && tick && last;
    end

    // state, pointer and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            an         <= AN_OFF;
            seg_out    <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            ptr        <= ptr_d;
            an         <= an_d;
            seg_out    <= seg_d;
            frame_done <= fd_d;
        end
    end

    a_one_anode: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(AN_ACTIVE_LO ? ~an : an));
endmodule

// File: tb/tb_seg_display_scanner.sv
// tb_seg_display_scanner: directed checks of scan timing, masking, live writes, disable and reset
module tb_seg_display_scanner;
    import seg_pkg::*;
    logic       clk = 1'b0;
    logic       rst_n, enable, wr_en, frame_done;
    logic [1:0] wr_idx;
    logic [7:0] wr_seg, seg_out;
    logic [3:0] blank_mask, an;
    logic [7:0] exp_code [4];
    int total = 0;
    int bad = 0;

    seg_display_scanner #(
        .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYC(2), .AN_ACTIVE_LO(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_seg(wr_seg), .blank_mask(blank_mask), .an(an), .seg_out(seg_out),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_off(input string tag);
        chk({tag, " an"}, 32'(an), 32'hF);
        chk({tag, " seg"}, 32'(seg_out), 32'hFF);
        chk({tag, " fd"}, 32'(frame_done), 32'h0);
    endtask

    task automatic wr(input logic [1:0] idx, input logic [7:0] val);
        wr_en = 1'b1;
        wr_idx = idx;
        wr_seg = val;
        step();
        wr_en = 1'b0;
    endtask

    // Called right after enable rises (#1 after an edge, cycle 0). Slot = 8 cycles:
    // 2 guard + 6 drive, registered outputs lag state by one, so digit d is shown at
    // cycles 4+8d..9+8d of each 32-cycle frame and frame_done pulses at 33, 65, ...
    // An optional write is driven after cycle wr_at; it becomes visible at wr_at+2.
    task automatic scan_check(input int ncyc, input logic [3:0] mask, input int wr_at,
                              input logic [1:0] idx, input logic [7:0] val);
        blank_mask = mask;
        for (int n = 1; n <= ncyc; n++) begin
            bit act;
            int d;
            step();
            if (n == wr_at + 1) wr_en = 1'b0;
            if (n == wr_at + 2) exp_code[idx] = val;
            act = n >= 4 && ((n - 4) % 8) < 6;
            d = n >= 4 ? ((n - 4) / 8) % 4 : 0;
            chk($sformatf("an n=%0d", n), 32'(an), act ? 32'(~(4'b1 << d) & 4'hF) : 32'hF);
            chk($sformatf("seg n=%0d", n), 32'(seg_out), act && !mask[d] ? 32'(exp_code[d]) : 32'hFF);
            chk($sformatf("fd n=%0d", n), 32'(frame_done), 32'(n >= 33 && (n - 33) % 32 == 0));
            if (n == wr_at) begin
                wr_en = 1'b1;
                wr_idx = idx;
                wr_seg = val;
            end
        end
    endtask

    task automatic stop_scan(input string tag);
        enable = 1'b0;
        blank_mask = 4'b0000;
        step();
        chk_off(tag);
    endtask

    initial begin
        rst_n = 1'b1;
        enable = 1'b0;
        wr_en = 1'b0;
        wr_idx = 2'd0;
        wr_seg = 8'h00;
        blank_mask = 4'b0000;
        #2 rst_n = 1'b0;
        #1 chk_off("reset");
        step();
        rst_n = 1'b1;
        wr(2'd0, SEG_ZERO);
        wr(2'd1, SEG_ONE);
        wr(2'd2, 8'h24);
        wr(2'd3, 8'h0C);
        exp_code = '{SEG_ZERO, SEG_ONE, 8'h24, 8'h0C};
        step();
        chk_off("idle after writes");
        enable = 1'b1;
        scan_check(70, 4'b0000, -10, 2'd0, 8'h00);
        stop_scan("stop scan");
        enable = 1'b1;
        scan_check(40, 4'b0100, -10, 2'd0, 8'h00);
        stop_scan("stop mask");
        enable = 1'b1;
        scan_check(40, 4'b0000, 12, 2'd1, 8'h12);
        stop_scan("stop live");
        enable = 1'b1;
        scan_check(20, 4'b0000, -10, 2'd0, 8'h00);
        stop_scan("disable mid digit2");
        for (int i = 0; i < 20; i++) begin
            step();
            chk_off($sformatf("idle %0d", i));
        end
        enable = 1'b1;
        scan_check(40, 4'b0000, -10, 2'd0, 8'h00);
        stop_scan("stop restart");
        enable = 1'b1;
        scan_check(40, 4'b0000, 16, 2'd2, 8'h40);
        stop_scan("stop collision");
        enable = 1'b1;
        scan_check(14, 4'b0000, -10, 2'd0, 8'h00);
        #2 rst_n = 1'b0;
        #1 chk_off("async reset");
        enable = 1'b0;
        step();
        rst_n = 1'b1;
        exp_code = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        step();
        enable = 1'b1;
        scan_check(36, 4'b0000, -10, 2'd0, 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
